// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  // Default width of the saturating match counter.
  localparam int DEFAULT_COUNT_W = 8;

  // Width needed by the fill counter so it can hold the values 0..pat_len.
  function automatic int fill_cnt_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module sat_counter #(
  parameter int             COUNT_W = 8,
  parameter logic [COUNT_W-1:0] SAT_VAL = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [COUNT_W-1:0] count_o
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Next count: clear first, otherwise step up until the ceiling is reached.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != SAT_VAL)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector: shifts qualified bits into a window, compares
// against a runtime-loadable pattern and pulses detect_out one cycle after the
// edge that sampled the final pattern bit. A fill counter tracks how many
// fresh bits the window holds; it doubles as the filling/armed state.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN         = 4,
  parameter logic [PAT_LEN-1:0] DEFAULT_PATTERN = PAT_LEN'(4'b1011),
  parameter int                 COUNT_W         = DEFAULT_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din_bit,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               pattern_load,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               detect_out,
  output logic [COUNT_W-1:0] match_count,
  output logic [PAT_LEN-1:0] window
);

  localparam int FW = fill_cnt_w(PAT_LEN);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);
  localparam logic [FW:0]   FILL_NEED = (FW + 1)'(PAT_LEN);

  logic [PAT_LEN-1:0] sr_q, sr_d;
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               detect_q, detect_d;

  logic [PAT_LEN-1:0] nw;
  logic [FW:0]        fill_inc;
  logic               armed;
  logic               match;

  // Candidate window with the newest bit entering at the LSB, and whether the
  // bit about to be shifted in completes PAT_LEN fresh bits.
  always_comb begin
    nw       = {sr_q[PAT_LEN-2:0], din_bit};
    fill_inc = {1'b0, fill_q} + (FW + 1)'(1);
    armed    = (fill_inc >= FILL_NEED);
  end

  // Next-state for window, fill counter and pattern; a pattern load wins over
  // any data bit arriving in the same cycle and restarts the history.
  always_comb begin
    sr_d      = sr_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    match     = 1'b0;
    if (pattern_load) begin
      pattern_d = pattern_in;
      sr_d      = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      sr_d  = nw;
      match = armed && (nw == pattern_q);
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FW'(1);
      end
      // Non-overlap: the matched bits cannot be reused, so start refilling.
      if (match && !overlap_en) begin
        fill_d = '0;
      end
    end
    detect_d = match;
  end

  // State registers; reset discards all partial history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      fill_q    <= '0;
      pattern_q <= DEFAULT_PATTERN;
      detect_q  <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      detect_q  <= detect_d;
    end
  end

  sat_counter #(
    .COUNT_W (COUNT_W),
    .SAT_VAL ({COUNT_W{1'b1}})
  ) u_match_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (match),
    .clr_i   (count_clr),
    .count_o (match_count)
  );

  assign detect_out = detect_q;
  assign window     = sr_q;

endmodule
